// File: rtl/byte_fifo_fwft.sv
// First-word-fall-through byte FIFO, single clock domain.
// The head entry is shown on read_data whenever not_empty is high; read_enable pops it.
module byte_fifo_fwft #(
    parameter int DEPTH = 512,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [7:0]       write_data,
    input  logic             read_enable,
    output logic [7:0]       read_data,
    output logic [CNT_W-1:0] slots_free,
    output logic             not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = read_enable && (count != '0);
    assign push_ok = write_enable && ((count != FULL_COUNT) || pop_ok);

    always_comb begin
        // NOTE: default first so every path assigns count_next and no latch is inferred.
        count_next = count;
        if (push_ok && !pop_ok)
            count_next = count + CNT_W'(1);
        else if (pop_ok && !push_ok)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            slots_free <= FULL_COUNT;
            not_empty  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            slots_free <= FULL_COUNT - count_next;
            not_empty  <= (count_next != '0);
        end
    end

    // NOTE: storage has no reset; stale bytes are never visible because not_empty gates them.
    always_ff @(posedge clock) begin
        if (push_ok && !reset)
            mem[wr_ptr] <= write_data;
    end

    assign read_data = mem[rd_ptr];

endmodule

// File: tb/tb_byte_fifo_fwft.sv
// Directed self-checking bench for byte_fifo_fwft (DEPTH=512).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_byte_fifo_fwft;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic [7:0] read_data;
    logic [9:0] slots_free;
    logic       not_empty;

    int n_vec = 0;
    int n_bad = 0;

    byte_fifo_fwft #(.DEPTH(512), .CNT_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .slots_free   (slots_free),
        .not_empty    (not_empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        write_enable = 1'b1;
        write_data   = b;
        tick();
        write_enable = 1'b0;
    endtask

    // Checks the head byte in the same cycle read_enable is raised, then pops it.
    task automatic pop_expect(input string tag, input logic [7:0] e);
        check(tag, {8'h0, read_data}, {8'h0, e});
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic ne, input logic [9:0] sf);
        check({tag, "_not_empty"}, {15'h0, not_empty}, {15'h0, ne});
        check({tag, "_slots_free"}, {6'h0, slots_free}, {6'h0, sf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        reset        = 1'b1;
        write_enable = 1'b0;
        write_data   = 8'h00;
        read_enable  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_state("reset", 1'b0, 10'd512);

        // Single byte in and out.
        push(8'h41);
        check_state("one_push", 1'b1, 10'd511);
        check("one_push_data", {8'h0, read_data}, 16'h0041);
        pop_expect("one_pop_data", 8'h41);
        check_state("one_pop", 1'b0, 10'd512);

        // Fill completely, overflow, drain in order.
        for (int i = 0; i < 512; i++) begin
            b = i[7:0];
            push(b);
        end
        check_state("full", 1'b1, 10'd0);
        push(8'hAA);
        check_state("overflow", 1'b1, 10'd0);
        for (int i = 0; i < 512; i++) begin
            b = i[7:0];
            pop_expect("drain_full", b);
        end
        check_state("drained", 1'b0, 10'd512);

        // Push+pop while empty: only the push lands.
        write_enable = 1'b1;
        write_data   = 8'h55;
        read_enable  = 1'b1;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_state("empty_pushpop", 1'b1, 10'd511);
        check("empty_pushpop_data", {8'h0, read_data}, 16'h0055);

        // Fill the rest with i^0x80, then push+pop while full.
        for (int i = 1; i < 512; i++) begin
            b = i[7:0] ^ 8'h80;
            push(b);
        end
        check_state("full2", 1'b1, 10'd0);
        check("full_pushpop_head", {8'h0, read_data}, 16'h0055);
        write_enable = 1'b1;
        write_data   = 8'hC3;
        read_enable  = 1'b1;
        tick();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_state("full_pushpop", 1'b1, 10'd0);
        for (int i = 1; i < 512; i++) begin
            b = i[7:0] ^ 8'h80;
            pop_expect("drain_full2", b);
        end
        check_state("last_left", 1'b1, 10'd511);
        pop_expect("last_out", 8'hC3);
        check_state("drained2", 1'b0, 10'd512);

        // Underflow is ignored.
        read_enable = 1'b1;
        tick();
        tick();
        read_enable = 1'b0;
        check_state("underflow", 1'b0, 10'd512);
        push(8'h12);
        push(8'h34);
        check_state("two_pushed", 1'b1, 10'd510);
        pop_expect("after_uf_0", 8'h12);
        pop_expect("after_uf_1", 8'h34);
        check_state("after_uf", 1'b0, 10'd512);

        // Pointer wrap with odd-length bursts.
        for (int i = 0; i < 300; i++) begin
            b = i[7:0] + 8'h11;
            push(b);
        end
        check_state("wrap300", 1'b1, 10'd212);
        for (int i = 0; i < 300; i++) begin
            b = i[7:0] + 8'h11;
            pop_expect("wrap300_data", b);
        end
        for (int i = 0; i < 400; i++) begin
            b = i[7:0] ^ 8'h5A;
            push(b);
        end
        check_state("wrap400", 1'b1, 10'd112);
        for (int i = 0; i < 400; i++) begin
            b = i[7:0] ^ 8'h5A;
            pop_expect("wrap400_data", b);
        end
        check_state("wrap_done", 1'b0, 10'd512);

        // Reset mid-traffic overrides a simultaneous push and pop.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        write_enable = 1'b1;
        write_data   = 8'hEE;
        read_enable  = 1'b1;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_state("mid_reset", 1'b0, 10'd512);
        push(8'h77);
        check_state("post_reset", 1'b1, 10'd511);
        pop_expect("post_reset_data", 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
